// File: rtl/bbox_pkg.sv
// bbox_pkg: constants and state encoding shared by the
// bounding-box raster scanner and its axis steppers.
package bbox_pkg;

    localparam int COORD_W    = 16;
    localparam int FRAC_BITS  = 6;
    localparam int PIXEL_STEP = 1 << FRAC_BITS;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Snap a coordinate down to its pixel grid position.
    function automatic coord_t pix_align(input coord_t c);
        return {c[COORD_W-1:FRAC_BITS], {FRAC_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/bbox_scanner_if.sv
// bbox_scanner_if: box-in and pixel-out handshake channels
// of the bounding-box scanner.
interface bbox_scanner_if;
    import bbox_pkg::*;

    logic   BOX_VALID;
    logic   BOX_READY;
    coord_t XMIN;
    coord_t XMAX;
    coord_t YMIN;
    coord_t YMAX;
    logic   PIX_VALID;
    logic   PIX_READY;
    coord_t PIX_X;
    coord_t PIX_Y;
    logic   PIX_LAST;

    modport master (
        output BOX_VALID, XMIN, XMAX, YMIN, YMAX, PIX_READY,
        input  BOX_READY, PIX_VALID, PIX_X, PIX_Y, PIX_LAST
    );

    modport slave (
        input  BOX_VALID, XMIN, XMAX, YMIN, YMAX, PIX_READY,
        output BOX_READY, PIX_VALID, PIX_X, PIX_Y, PIX_LAST
    );

endinterface

// File: rtl/bbox_scanner_axis_stepper.sv
// axis_stepper: one scan axis; latches a [min,max] range and
// walks it in pixel steps, wrapping back to min after max.
module axis_stepper
    import bbox_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_load,
    input  coord_t i_min,
    input  coord_t i_max,
    input  logic   i_step,
    output coord_t o_pos,
    output logic   o_at_max
);

    coord_t r_min;
    coord_t r_max;
    coord_t r_pos;

    // Load rewinds to min; a step advances or wraps at max.
    // Max is tested before incrementing, so 0xFFC0 never overflows.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_min <= '0;
            r_max <= '0;
            r_pos <= '0;
        end else if (i_load) begin
            r_min <= i_min;
            r_max <= i_max;
            r_pos <= i_min;
        end else if (i_step) begin
            if (r_pos == r_max)
                r_pos <= r_min;
            else
                r_pos <= r_pos + coord_t'(PIXEL_STEP);
        end
    end

    assign o_pos    = r_pos;
    assign o_at_max = (r_pos == r_max);

endmodule

// File: rtl/bbox_scanner.sv
// bbox_scanner: accepts a pixel-aligned bounding box and emits
// every pixel inside it in raster order over a valid/ready link.
module bbox_scanner
    import bbox_pkg::*;
(
    input  logic           CLK,
    input  logic           RST,
    bbox_scanner_if.slave  bus,
    input  logic           ABORT,
    output logic           DONE,
    output logic           BUSY
);

    state_t r_state;
    logic   r_pix_valid;
    logic   r_done;
    logic   r_box_ready;
    logic   r_busy;

    coord_t w_xmin;
    coord_t w_xmax;
    coord_t w_ymin;
    coord_t w_ymax;
    coord_t w_pix_x;
    coord_t w_pix_y;
    logic   w_box_acc;
    logic   w_empty;
    logic   w_xfer;
    logic   w_last;
    logic   w_x_step;
    logic   w_y_step;
    logic   w_x_at_max;
    logic   w_y_at_max;

    assign w_xmin    = pix_align(bus.XMIN);
    assign w_xmax    = pix_align(bus.XMAX);
    assign w_ymin    = pix_align(bus.YMIN);
    assign w_ymax    = pix_align(bus.YMAX);
    assign w_box_acc = (r_state == ST_IDLE) && bus.BOX_VALID;
    assign w_empty   = (w_xmin > w_xmax) || (w_ymin > w_ymax);
    assign w_xfer    = r_pix_valid && bus.PIX_READY;
    assign w_last    = r_pix_valid && w_x_at_max && w_y_at_max;
    // An abort discards the scan, so the position is not advanced.
    assign w_x_step  = (r_state == ST_SCAN) && w_xfer && !ABORT;
    assign w_y_step  = w_x_step && w_x_at_max;

    axis_stepper u_x (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_load   (w_box_acc),
        .i_min    (w_xmin),
        .i_max    (w_xmax),
        .i_step   (w_x_step),
        .o_pos    (w_pix_x),
        .o_at_max (w_x_at_max)
    );

    axis_stepper u_y (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_load   (w_box_acc),
        .i_min    (w_ymin),
        .i_max    (w_ymax),
        .i_step   (w_y_step),
        .o_pos    (w_pix_y),
        .o_at_max (w_y_at_max)
    );

    // Scan control with registered handshake and status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_pix_valid <= 1'b0;
            r_done      <= 1'b0;
            r_box_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_box_acc) begin
                        r_box_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_empty) begin
                            r_state <= ST_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= ST_SCAN;
                            r_pix_valid <= 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (ABORT) begin
                        r_state     <= ST_IDLE;
                        r_pix_valid <= 1'b0;
                        r_box_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end else if (w_xfer && w_last) begin
                        r_state     <= ST_FINISH;
                        r_pix_valid <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    r_state     <= ST_IDLE;
                    r_box_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_pix_valid <= 1'b0;
                    r_box_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.BOX_READY = r_box_ready;
    assign bus.PIX_VALID = r_pix_valid;
    assign bus.PIX_X     = w_pix_x;
    assign bus.PIX_Y     = w_pix_y;
    assign bus.PIX_LAST  = w_last;
    assign DONE          = r_done;
    assign BUSY          = r_busy;

endmodule
